rv_multicycle_ctrl: RTL and testbench

//  Multi-cycle RV32I control FSM. Successor to the single-cycle combinational decoder.

---
 rtl/rv_pkg.sv | 51 +++++
 rtl/rv_alu_decode.sv | 43 ++++
 rtl/rv_multicycle_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle RV32I controller:
// opcodes, ALU and immediate codes, FSM states.
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_UPPER, S_TRAP
  } state_t;

  // alt selects sub for funct3 000 and sra for funct3 101
  function automatic logic [3:0] funct3_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  funct3_alu = alt ? ALU_SUB : ALU_ADD;
      3'b001:  funct3_alu = ALU_SLL;
      3'b010:  funct3_alu = ALU_SLT;
      3'b011:  funct3_alu = ALU_SLTU;
      3'b100:  funct3_alu = ALU_XOR;
      3'b101:  funct3_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  funct3_alu = ALU_OR;
      default: funct3_alu = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_alu_decode.sv
// Combinational instruction check and ALU operation select
// from opcode, funct3 and funct7.
module rv_alu_decode
  import rv_pkg::*;
#(
  parameter bit EN_BRANCH = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC: legal = 1'b1;
      OP_R: begin
        alu_control = funct3_alu(funct3, funct7[5]);
        legal = (funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OP_I: begin
        // addi has no subtract form, so funct7 only matters for shifts
        alu_control = funct3_alu(funct3, (funct3 == 3'b101) && funct7[5]);
        case (funct3)
          3'b001:  legal = (funct7 == 7'h00);
          3'b101:  legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: legal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        alu_control = ALU_SUB;
        legal       = EN_BRANCH && (funct3[2:1] != 2'b01);
      end
      OP_JAL, OP_JALR: legal = EN_BRANCH;
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM driving datapath selects and enables,
// with a memory ready handshake, access timeout and illegal-opcode trap.
//
// state    | meaning
// FETCH    | read instr at PC, PC <= PC + 4 on ready
// DECODE   | branch/jal target = oldPC + imm into ALU result reg
// MEMADR   | rs1 + imm address for lw/sw
// MEMRD    | load access, wait for ready
// MEMWB    | write load data to rd
// MEMWR    | store access, wait for ready
// EXEC_R   | rs1 op rs2
// EXEC_I   | rs1 op imm
// ALUWB    | write ALU result reg to rd
// BRANCH   | compare rs1/rs2, PC <= target if taken
// JAL      | PC <= target, compute oldPC + 4
// JALR     | PC <= rs1 + imm
// UPPER    | lui / auipc
// TRAP     | halted until reset
module rv_multicycle_ctrl
  import rv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter bit EN_BRANCH   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic        adr_src,
  output logic        mem_req,
  output logic        mem_wr,
  output logic        reg_wr,
  output logic [2:0]  imm_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_control,
  output logic [1:0]  result_src,
  output logic        illegal,
  output logic        bus_err
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [3:0]    dec_alu;
  logic          dec_legal, mem_phase, waiting, time_out, taken;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign mem_phase = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign waiting   = mem_phase && !mem_ready;
  assign time_out  = (MEM_TIMEOUT != 0) && waiting && (timer == T_LAST);

  rv_alu_decode #(.EN_BRANCH(EN_BRANCH)) u_alu_decode (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (instr[31:25]),
    .alu_control (dec_alu),
    .legal       (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      timer   <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= waiting ? timer + TW'(1) : '0;
      if ((state == S_DECODE) && (state_nxt == S_TRAP)) illegal <= 1'b1;
      if (time_out) bus_err <= 1'b1;
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    ir_wr       = 1'b0;
    pc_wr       = 1'b0;
    adr_src     = 1'b0;
    mem_req     = 1'b0;
    mem_wr      = 1'b0;
    reg_wr      = 1'b0;
    imm_src     = IMM_I;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    result_src  = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_wr     = 1'b1;
          pc_wr     = 1'b1;
          state_nxt = S_DECODE;
        end else if (time_out) begin
          state_nxt = S_TRAP;
        end
      end
      S_DECODE: begin
        // jal takes its target from here, so it needs the J immediate
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        if (!dec_legal) state_nxt = S_TRAP;
        else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
            OP_R:              state_nxt = S_EXEC_R;
            OP_I:              state_nxt = S_EXEC_I;
            OP_BRANCH:         state_nxt = S_BRANCH;
            OP_JAL:            state_nxt = S_JAL;
            OP_JALR:           state_nxt = S_JALR;
            OP_LUI, OP_AUIPC:  state_nxt = S_UPPER;
            default:           state_nxt = S_TRAP;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_nxt = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)     state_nxt = S_MEMWB;
        else if (time_out) state_nxt = S_TRAP;
      end
      S_MEMWB: begin
        reg_wr     = 1'b1;
        result_src = 2'b01;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_wr  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)     state_nxt = S_FETCH;
        else if (time_out) state_nxt = S_TRAP;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_control = dec_alu;
        state_nxt   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = dec_alu;
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr    = 1'b1;
        state_nxt = S_FETCH;
        // the result reg holds the jalr target, so link value is formed directly
        if (opcode == OP_JALR) begin
          alu_src_a  = 2'b01;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
        end
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_wr       = taken;
        state_nxt   = S_FETCH;
      end
      S_JAL: begin
        pc_wr     = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_JALR: begin
        pc_wr      = 1'b1;
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        state_nxt  = S_ALUWB;
      end
      S_UPPER: begin
        // A select 11 feeds zero for lui
        alu_src_a = (opcode == OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        imm_src   = IMM_U;
        state_nxt = S_ALUWB;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: inputs change on the falling edge,
// outputs are compared 1 ns later against hand-computed values.
module tb_rv_multicycle_ctrl;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LW    = 32'h0040A283;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BLT   = 32'h0020C463;
  localparam logic [31:0] I_BGEU  = 32'h0020F463;
  localparam logic [31:0] I_SRAI  = 32'h4030D093;
  localparam logic [31:0] I_BADR  = 32'h402091B3;
  localparam logic [31:0] I_OP7F  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0, alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
  logic        ir_wr, pc_wr, adr_src, mem_req, mem_wr, reg_wr, illegal, bus_err;
  logic [2:0]  imm_src;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [3:0]  alu_control;

  int n_chk = 0;
  int n_fail = 0;

  rv_multicycle_ctrl #(.MEM_TIMEOUT(4), .EN_BRANCH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .adr_src(adr_src), .mem_req(mem_req),
    .mem_wr(mem_wr), .reg_wr(reg_wr), .imm_src(imm_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .result_src(result_src),
    .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input bit full);
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    alu_zero = 1'b0;
    alu_lt = 1'b0;
    alu_ltu = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 1);
    check("rst_ir_wr", ir_wr, 0);
    check("rst_illegal", illegal, 0);
    check("rst_bus_err", bus_err, 0);
    if (full) begin
      check("rst_adr_src", adr_src, 0);
      check("rst_pc_wr", pc_wr, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_reg_wr", reg_wr, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // FETCH with immediate ready, then through DECODE; ends at the third state's falling edge
  task automatic fetch_decode(input logic [31:0] ins);
    instr = ins;
    mem_ready = 1'b1;
    #1;
    tick();
    mem_ready = 1'b0;
    #1;
    tick();
  endtask

  task automatic run_branch(input string tag, input logic [31:0] ins, input logic z,
                            input logic lt, input logic ltu, input logic exp_pc);
    do_reset(1'b0);
    fetch_decode(ins);
    alu_zero = z;
    alu_lt = lt;
    alu_ltu = ltu;
    #1;
    check({tag, "_pc_wr"}, pc_wr, exp_pc);
    check({tag, "_alu_sub"}, alu_control, 1);
    tick();
    #1;
    check({tag, "_back_fetch"}, mem_req, 1);
  endtask

  initial begin
    // add: FETCH, DECODE, EXEC_R, ALUWB
    do_reset(1'b1);
    instr = I_ADD;
    mem_ready = 1'b1;
    #1;
    check("add_c1_ir_wr", ir_wr, 1);
    check("add_c1_pc_wr", pc_wr, 1);
    check("add_c1_reg_wr", reg_wr, 0);
    tick();
    #1;
    check("add_c2_reg_wr", reg_wr, 0);
    check("add_c2_mem_req", mem_req, 0);
    tick();
    #1;
    check("add_c3_alu", alu_control, 0);
    check("add_c3_src_a", alu_src_a, 2);
    check("add_c3_reg_wr", reg_wr, 0);
    tick();
    #1;
    check("add_c4_reg_wr", reg_wr, 1);
    check("add_c4_result_src", result_src, 0);
    tick();
    #1;
    check("add_c5_reg_wr", reg_wr, 0);
    check("add_c5_mem_req", mem_req, 1);

    // lw with ready three cycles late in MEMRD
    do_reset(1'b0);
    fetch_decode(I_LW);
    #1;
    check("lw_adr_src_a", alu_src_a, 2);
    check("lw_adr_src_b", alu_src_b, 1);
    check("lw_adr_imm", imm_src, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("lw_wait%0d_req", i), mem_req, 1);
      check($sformatf("lw_wait%0d_adr", i), adr_src, 1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("lw_ready_req", mem_req, 1);
    check("lw_ready_reg_wr", reg_wr, 0);
    tick();
    mem_ready = 1'b0;
    #1;
    check("lw_wb_reg_wr", reg_wr, 1);
    check("lw_wb_result_src", result_src, 1);
    check("lw_wb_mem_req", mem_req, 0);
    check("lw_bus_err", bus_err, 0);
    tick();
    #1;
    check("lw_next_fetch", mem_req, 1);

    // branches
    run_branch("beq_t", I_BEQ, 1'b1, 1'b0, 1'b0, 1'b1);
    run_branch("beq_nt", I_BEQ, 1'b0, 1'b0, 1'b0, 1'b0);
    run_branch("blt_t", I_BLT, 1'b0, 1'b1, 1'b0, 1'b1);
    run_branch("bgeu_nt", I_BGEU, 1'b0, 1'b0, 1'b1, 1'b0);

    // srai selects arithmetic shift
    do_reset(1'b0);
    fetch_decode(I_SRAI);
    #1;
    check("srai_alu", alu_control, 7);
    check("srai_src_b", alu_src_b, 1);

    // illegal opcode traps and stays until reset
    do_reset(1'b0);
    instr = I_OP7F;
    mem_ready = 1'b1;
    #1;
    tick();
    #1;
    check("op7f_dec_illegal", illegal, 0);
    tick();
    #1;
    check("op7f_illegal", illegal, 1);
    check("op7f_mem_req", mem_req, 0);
    check("op7f_pc_wr", pc_wr, 0);
    tick();
    #1;
    check("op7f_hold_ir_wr", ir_wr, 0);
    check("op7f_hold_illegal", illegal, 1);
    do_reset(1'b0);
    #1;
    check("op7f_release_illegal", illegal, 0);
    check("op7f_release_fetch", mem_req, 1);

    // R-type sll with funct7 = 0x20 is illegal
    do_reset(1'b0);
    fetch_decode(I_BADR);
    #1;
    check("badr_illegal", illegal, 1);
    check("badr_reg_wr", reg_wr, 0);

    // memory timeout in FETCH
    do_reset(1'b0);
    instr = I_ADD;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("to_c%0d_req", i), mem_req, 1);
      check($sformatf("to_c%0d_bus_err", i), bus_err, 0);
      tick();
    end
    #1;
    check("to_bus_err", bus_err, 1);
    check("to_trap_req", mem_req, 0);
    check("to_not_illegal", illegal, 0);

    // ready on the last allowed cycle wins
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("late_ir_wr", ir_wr, 1);
    tick();
    mem_ready = 1'b0;
    #1;
    check("late_bus_err", bus_err, 0);
    check("late_decode_req", mem_req, 0);
    tick();
    #1;
    check("late_exec_alu", alu_control, 0);

    // asynchronous reset during a store
    do_reset(1'b0);
    fetch_decode(I_SW);
    #1;
    check("sw_imm_s", imm_src, 1);
    tick();
    #1;
    check("sw_mem_wr", mem_wr, 1);
    check("sw_adr_src", adr_src, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("sw_rst_mem_wr", mem_wr, 0);
    check("sw_rst_adr_src", adr_src, 0);
    check("sw_rst_mem_req", mem_req, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("sw_after_fetch", mem_req, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
